xcorr_sig_gen: RTL

//  Transmit side of the cross-correlation link. Takes an NDATA-bit reference

---
 rtl/xcorr_sig_gen.sv | 95 +++++++++
 1 files changed

// File: rtl/xcorr_sig_gen.sv
// Cross-correlation link transmitter: latches a reference word, rotates it right by the programmed lag,
// then streams it MSB-first over a valid/ready bit interface. A stalled sink holds the stream indefinitely.
module xcorr_sig_gen #(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NDATA-1:0]     dinRef,
  input  logic [NDATA_LOG-1:0] lag,
  output logic                 busy,
  output logic [NDATA-1:0]     sigWord,
  output logic                 doutBit,
  output logic                 doutValid,
  input  logic                 doutReady,
  output logic                 doutLast,
  output logic [NDATA_LOG-1:0] cntout,
  output logic                 done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [NDATA_LOG-1:0] CNT_LAST = NDATA_LOG'(NDATA - 1);
  localparam logic [NDATA_LOG-1:0] LAG_ONE  = NDATA_LOG'(1);

  logic [1:0]           state_q, state_d;
  logic [NDATA-1:0]     sig_word_q, sig_word_d;
  logic [NDATA_LOG-1:0] cnt_q, cnt_d;
  logic [NDATA_LOG-1:0] lag_cnt_q, lag_cnt_d;

  always_comb begin
    state_d    = state_q;
    sig_word_d = sig_word_q;
    cnt_d      = cnt_q;
    lag_cnt_d  = lag_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_word_d = dinRef;
          lag_cnt_d  = lag;
          cnt_d      = '0;
          state_d    = (lag != '0) ? ALIGN : SEND;
        end
      end
      ALIGN: begin
        sig_word_d = {sig_word_q[0], sig_word_q[NDATA-1:1]};
        lag_cnt_d  = lag_cnt_q - LAG_ONE;
        if (lag_cnt_q <= LAG_ONE) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (doutReady) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + LAG_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sig_word_q <= '0;
      cnt_q      <= '0;
      lag_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sig_word_q <= sig_word_d;
      cnt_q      <= cnt_d;
      lag_cnt_q  <= lag_cnt_d;
    end
  end

  // NDATA is a power of two, so NDATA-1-cnt is simply the bitwise inverse of cnt.
  assign doutBit   = sig_word_q[~cnt_q];
  assign sigWord   = sig_word_q;
  assign cntout    = cnt_q;
  assign busy      = (state_q != IDLE);
  assign doutValid = (state_q == SEND);
  assign doutLast  = (state_q == SEND) && (cnt_q == CNT_LAST);
  assign done      = (state_q == DONE);

endmodule
